// File: rtl/i2s_xfer_ctrl_if.sv
// Register-side and shift-engine-side signals of the I2S transfer controller.
// slave: controller view; master: register file / shift engine view.
interface i2s_xfer_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       controls;
  logic [DATA_W-1:0] tx_reg;
  logic              tx_wr;
  logic              rx_rd;
  logic              ser_req;
  logic [DATA_W-1:0] ser_data;
  logic              ser_valid;
  logic              des_valid;
  logic [DATA_W-1:0] des_data;
  logic              reg_wen;
  logic              reg_ren;
  logic [DATA_W-1:0] rx_data;
  logic [3:0]        status;
  logic              irq;

  modport slave (
    input  controls, tx_reg, tx_wr, rx_rd,
    input  ser_req, des_valid, des_data,
    output ser_data, ser_valid, reg_wen,
    output reg_ren, rx_data, status, irq
  );

  modport master (
    output controls, tx_reg, tx_wr, rx_rd,
    output ser_req, des_valid, des_data,
    input  ser_data, ser_valid, reg_wen,
    input  reg_ren, rx_data, status, irq
  );
endinterface

// File: rtl/i2s_xfer_ctrl.sv
// I2S word transfer sequencer: TX double buffer, RX capture, sticky flags.
// Define I2S_XFER_CTRL_IRQ_EN to drive a registered interrupt on irq.
module i2s_xfer_ctrl #(
  parameter int DATA_W    = 32,
  parameter int EN_BIT    = 0,
  parameter int TX_EN_BIT = 1,
  parameter int RX_EN_BIT = 2,
  parameter int CLR_BIT   = 3
) (
  input logic            pclk,
  input logic            presetn,
  i2s_xfer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    TX_OFF,
    TX_EMPTY,
    TX_LOAD,
    TX_FULL
  } tx_state_t;

  tx_state_t         state;
  logic [DATA_W-1:0] shadow;
  logic              pend;
  logic [DATA_W-1:0] rx_data;
  logic              rx_full;
  logic              tx_udr;
  logic              rx_ovr;

  logic tx_on;
  logic rx_on;
  logic clr;
  logic tx_empty;
  logic ctl_unused;

  assign ctl_unused = ^bus.controls;

  assign tx_on = bus.controls[EN_BIT]
               & bus.controls[TX_EN_BIT];
  assign rx_on = bus.controls[EN_BIT]
               & bus.controls[RX_EN_BIT];
  assign clr   = bus.controls[CLR_BIT];

  // Word handover to the serializer
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state  <= TX_OFF;
      shadow <= '0;
      pend   <= 1'b0;
    end else if (!tx_on) begin
      state  <= TX_OFF;
      shadow <= '0;
      pend   <= 1'b0;
    end else begin
      unique case (state)
        TX_OFF: state <= TX_EMPTY;
        TX_EMPTY: begin
          if (bus.tx_wr) state <= TX_LOAD;
        end
        TX_LOAD: begin
          shadow <= bus.tx_reg;
          state  <= TX_FULL;
        end
        TX_FULL: begin
          if (bus.ser_req) begin
            pend  <= 1'b0;
            state <= (pend | bus.tx_wr)
                   ? TX_LOAD : TX_EMPTY;
          end else if (bus.tx_wr && !pend) begin
            pend <= 1'b1;
          end
        end
        default: state <= TX_OFF;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rx_data <= '0;
      rx_full <= 1'b0;
    end else if (!rx_on) begin
      rx_full <= 1'b0;
    end else if (bus.des_valid) begin
      rx_data <= bus.des_data;
      rx_full <= 1'b1;
    end else if (bus.rx_rd) begin
      rx_full <= 1'b0;
    end
  end

  // Clear dominates set; flags outlive disable
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tx_udr <= 1'b0;
      rx_ovr <= 1'b0;
    end else if (clr) begin
      tx_udr <= 1'b0;
      rx_ovr <= 1'b0;
    end else begin
      if (bus.ser_req &&
          (state == TX_EMPTY ||
           state == TX_LOAD))
        tx_udr <= 1'b1;
      if (rx_on && bus.des_valid &&
          rx_full && !bus.rx_rd)
        rx_ovr <= 1'b1;
    end
  end

  assign tx_empty      = (state == TX_EMPTY);
  assign bus.ser_data  = shadow;
  assign bus.ser_valid = (state == TX_FULL);
  assign bus.reg_wen   = tx_empty
                       | ((state == TX_FULL) & ~pend);
  assign bus.reg_ren   = rx_full;
  assign bus.rx_data   = rx_data;
  assign bus.status    = {rx_ovr, tx_udr,
                          rx_full, tx_empty};

`ifdef I2S_XFER_CTRL_IRQ_EN
  logic irq_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= tx_udr | rx_ovr
             | (rx_full & rx_on)
             | (tx_empty & tx_on);
    end
  end

  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_xfer_ctrl.sv
// Directed self-checking bench for i2s_xfer_ctrl.
// Expected irq follows I2S_XFER_CTRL_IRQ_EN.
module tb_i2s_xfer_ctrl;

  logic pclk;
  logic presetn;
  int   n_chk;
  int   n_fail;

`ifdef I2S_XFER_CTRL_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  i2s_xfer_ctrl_if #(.DATA_W(32)) bus ();

  i2s_xfer_ctrl #(.DATA_W(32)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    presetn       = 1'b0;
    bus.controls  = 32'h0;
    bus.tx_reg    = 32'h0;
    bus.tx_wr     = 1'b0;
    bus.rx_rd     = 1'b0;
    bus.ser_req   = 1'b0;
    bus.des_valid = 1'b0;
    bus.des_data  = 32'h0;
    repeat (3) tick();

    // reset state
    check("rst_reg_wen", {31'b0, bus.reg_wen}, 0);
    check("rst_ser_valid", {31'b0, bus.ser_valid}, 0);
    check("rst_status", {28'b0, bus.status}, 0);
    check("rst_ser_data", bus.ser_data, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_reg_ren", {31'b0, bus.reg_ren}, 0);
    check("rst_irq", {31'b0, bus.irq}, 0);

    presetn      = 1'b1;
    bus.controls = 32'h3;
    tick();
    check("en_reg_wen", {31'b0, bus.reg_wen}, 1);
    check("en_status", {28'b0, bus.status}, 32'h1);

    // single word, 2-cycle latency
    bus.tx_reg = 32'hA5A5_0001;
    bus.tx_wr  = 1'b1;
    tick();
    bus.tx_wr = 1'b0;
    check("t2_n1_valid", {31'b0, bus.ser_valid}, 0);
    check("t2_n1_wen", {31'b0, bus.reg_wen}, 0);
    tick();
    check("t2_n2_valid", {31'b0, bus.ser_valid}, 1);
    check("t2_n2_data", bus.ser_data, 32'hA5A5_0001);
    check("t2_n2_status", {28'b0, bus.status}, 0);
    check("t2_n2_wen", {31'b0, bus.reg_wen}, 1);
    bus.ser_req = 1'b1;
    tick();
    bus.ser_req = 1'b0;
    check("t2_req_valid", {31'b0, bus.ser_valid}, 0);
    check("t2_req_status", {28'b0, bus.status}, 32'h1);

    // pending second word
    bus.tx_reg = 32'h0000_0011;
    bus.tx_wr  = 1'b1;
    tick();
    bus.tx_wr = 1'b0;
    tick();
    check("t3_first", bus.ser_data, 32'h11);
    bus.tx_reg = 32'h0000_0002;
    bus.tx_wr  = 1'b1;
    tick();
    check("t3_pend_wen", {31'b0, bus.reg_wen}, 0);
    check("t3_pend_data", bus.ser_data, 32'h11);
    tick();
    bus.tx_wr = 1'b0;
    check("t3_blk_wen", {31'b0, bus.reg_wen}, 0);
    check("t3_blk_valid", {31'b0, bus.ser_valid}, 1);
    bus.ser_req = 1'b1;
    tick();
    bus.ser_req = 1'b0;
    check("t3_load_valid", {31'b0, bus.ser_valid}, 0);
    check("t3_load_wen", {31'b0, bus.reg_wen}, 0);
    tick();
    check("t3_full_data", bus.ser_data, 32'h2);
    check("t3_full_valid", {31'b0, bus.ser_valid}, 1);
    check("t3_full_wen", {31'b0, bus.reg_wen}, 1);
    bus.ser_req = 1'b1;
    tick();
    bus.ser_req = 1'b0;
    check("t3_drain_status", {28'b0, bus.status}, 32'h1);

    // underrun and clear
    bus.ser_req = 1'b1;
    tick();
    bus.ser_req = 1'b0;
    check("t4_udr", {28'b0, bus.status}, 32'h5);
    bus.controls = 32'hB;
    bus.ser_req  = 1'b1;
    tick();
    bus.ser_req  = 1'b0;
    bus.controls = 32'h3;
    check("t4_clr_wins", {28'b0, bus.status}, 32'h1);
    bus.ser_req = 1'b1;
    tick();
    bus.ser_req = 1'b0;
    check("t4_udr_again", {28'b0, bus.status}, 32'h5);
    bus.controls = 32'h1;
    tick();
    check("t4_off_status", {28'b0, bus.status}, 32'h4);
    check("t4_off_wen", {31'b0, bus.reg_wen}, 0);
    bus.controls = 32'h9;
    tick();
    check("t4_clr_off", {28'b0, bus.status}, 0);

    // reset mid TX_FULL
    bus.controls = 32'h3;
    tick();
    bus.tx_reg = 32'h0000_0077;
    bus.tx_wr  = 1'b1;
    tick();
    bus.tx_wr = 1'b0;
    tick();
    check("t1_full_valid", {31'b0, bus.ser_valid}, 1);
    presetn = 1'b0;
    #1;
    check("t1_rst_valid", {31'b0, bus.ser_valid}, 0);
    check("t1_rst_data", bus.ser_data, 0);
    check("t1_rst_wen", {31'b0, bus.reg_wen}, 0);
    check("t1_rst_status", {28'b0, bus.status}, 0);
    check("t1_rst_irq", {31'b0, bus.irq}, 0);
    tick();
    presetn = 1'b1;
    tick();
    check("t1_rel_wen", {31'b0, bus.reg_wen}, 1);

    // RX capture, overrun, simultaneous read
    bus.controls = 32'h5;
    repeat (2) tick();
    check("t5_idle_irq", {31'b0, bus.irq}, 0);
    bus.des_data  = 32'h1234;
    bus.des_valid = 1'b1;
    tick();
    check("t5_w1_data", bus.rx_data, 32'h1234);
    check("t5_w1_status", {28'b0, bus.status}, 32'h2);
    check("t5_w1_ren", {31'b0, bus.reg_ren}, 1);
    check("t6_w1_irq", {31'b0, bus.irq}, 0);
    bus.des_data = 32'h5678;
    tick();
    bus.des_valid = 1'b0;
    check("t5_w2_data", bus.rx_data, 32'h5678);
    check("t5_w2_status", {28'b0, bus.status}, 32'hA);
    check("t6_w2_irq", {31'b0, bus.irq}, {31'b0, IRQ_EN});
    bus.controls = 32'hD;
    tick();
    bus.controls = 32'h5;
    check("t5_clr_status", {28'b0, bus.status}, 32'h2);
    bus.des_data  = 32'h9ABC;
    bus.des_valid = 1'b1;
    bus.rx_rd     = 1'b1;
    tick();
    bus.des_valid = 1'b0;
    check("t5_both_data", bus.rx_data, 32'h9ABC);
    check("t5_both_status", {28'b0, bus.status}, 32'h2);
    tick();
    bus.rx_rd = 1'b0;
    check("t5_rd_status", {28'b0, bus.status}, 0);
    check("t5_rd_ren", {31'b0, bus.reg_ren}, 0);
    bus.controls  = 32'h1;
    bus.des_data  = 32'hDEAD;
    bus.des_valid = 1'b1;
    tick();
    bus.des_valid = 1'b0;
    check("t5_off_data", bus.rx_data, 32'h9ABC);
    check("t5_off_ren", {31'b0, bus.reg_ren}, 0);
    tick();
    check("t6_end_irq", {31'b0, bus.irq}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
